// File: rtl/stack_arbiter_if.sv
// Requester-side bus for stack_arbiter: two request ports plus the shared response.
interface stack_arbiter_if #(parameter int WIDTH = 8);
  logic             req0, op0;
  logic [WIDTH-1:0] wdata0;
  logic             req1, op1;
  logic [WIDTH-1:0] wdata1;
  logic             ack0, ack1, err;
  logic [WIDTH-1:0] rdata;

  modport master (output req0, op0, wdata0, req1, op1, wdata1,
                  input  ack0, ack1, err, rdata);
  modport slave  (input  req0, op0, wdata0, req1, op1, wdata1,
                  output ack0, ack1, err, rdata);
endinterface

// File: rtl/stack_arbiter.sv
// Two-port arbiter in front of a single LIFO: serialises push/pop into one-cycle
// stack enables, tracks occupancy and rejects overflow/underflow.
module stack_arbiter #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 1,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  stack_arbiter_if.slave   bus,
  output logic             stk_c,
  output logic             stk_en,
  output logic [WIDTH-1:0] stk_push,
  input  logic [WIDTH-1:0] stk_peek,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty
);
  localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] ONE = {{DEPTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t           state;
  logic             last_grant, grant, bad;
  logic             ack0, ack1, err;
  logic [WIDTH-1:0] rdata;

  logic             pick1, sel_op, legal;
  logic [WIDTH-1:0] sel_data;

  // Round-robin favours the port that lost last time; only matters when both ask.
  always_comb begin
    pick1 = 1'b0;
    if (FIXED_PRI)                 pick1 = !bus.req0;
    else if (bus.req0 && bus.req1) pick1 = !last_grant;
    else                           pick1 = !bus.req0;
  end

  assign sel_op   = pick1 ? bus.op1    : bus.op0;
  assign sel_data = pick1 ? bus.wdata1 : bus.wdata0;
  assign legal    = sel_op ? (count != '0) : (count != CAP);

  assign full  = (count == CAP);
  assign empty = (count == '0);

  assign bus.ack0  = ack0;
  assign bus.ack1  = ack1;
  assign bus.err   = err;
  assign bus.rdata = rdata;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      bad        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      stk_c      <= 1'b0;
      stk_en     <= 1'b0;
      stk_push   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req0 || bus.req1) begin
          grant      <= pick1;
          last_grant <= pick1;
          stk_c      <= sel_op;
          stk_push   <= sel_data;
          // Legality is decided here so the enable lands exactly on the ISSUE cycle.
          stk_en     <= legal;
          bad        <= !legal;
          state      <= ISSUE;
        end
        ISSUE: begin
          stk_en <= 1'b0;
          if (!bad) begin
            if (stk_c) begin
              rdata <= stk_peek;
              count <= count - ONE;
            end else begin
              count <= count + ONE;
            end
          end
          err   <= bad;
          ack0  <= !grant;
          ack1  <= grant;
          state <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
